// File: rtl/seg_scan_display_n.sv
// Multiplexed 7-segment driver: valid/ready binary input, sequential double-dabble BCD conversion,
// prescaled digit scan, leading-zero blanking, decimal points, overflow dashes. Optional: SEG_BLINK_EN.
module seg_scan_display_n #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 50000,
  parameter int LZ_BLANK   = 1,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [NUM_DIGITS-1:0] dp_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic [7:0]            seg_data,
  output logic                  busy,
  output logic                  ovf
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int CNT_W   = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [7:0]            seg_q, seg_d;

  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  blank_blink;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Per-digit add-3 correction and leading-zero detection (digit 0 is never blanked)
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit[gi] = disp_q[4*gi +: 4];
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                           : bcd_q[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      assign blank_vec[gi] = (LZ_BLANK != 0) && (disp_q[BCD_W-1:4*gi] == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          bin_d      = data_in;
          bcd_d      = '0;
          cnt_d      = CNT_W'(DATA_W);
          ovf_pend_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: begin
        // A 1 leaving the top nibble means the value needs more digits than we have
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        if (bcd_adj[BCD_W-1]) ovf_pend_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        ovf_d   = ovf_pend_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_on_d  = blink_on_q;
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end

  assign blank_blink = ~blink_on_q & blink_mask[idx_q];
`else
  assign blank_blink = 1'b0;
`endif

  // Digit enable and segments come from the same index so the pins never skew
  always_comb begin
    dig_sel_d = NUM_DIGITS'(1) << idx_q;
    seg_d     = {1'b0, glyph(digit[idx_q])};
    if (ovf_q)                 seg_d = 8'h40;
    else if (blank_vec[idx_q]) seg_d = 8'h00;
    seg_d[7] = dp_mask[idx_q];
    if (blank_blink) seg_d = 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      dig_sel_q  <= '0;
      seg_q      <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign data_ready = ~busy;
  assign dig_sel    = dig_sel_q;
  assign seg_data   = seg_q;
  assign ovf        = ovf_q;

endmodule
